// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: single outstanding load/store over valid/ready
// request and response channels, with a byte-enabled word store and programmable wait states.
module data_mem_responder #(
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2,
   parameter int CNT_W   = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_be_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        busy_o
);

   localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [29:0]      DEPTH_W = 30'(DEPTH);
   localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LATENCY);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic [31:0]       mem_q [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic [31:0]       rd_word;
   logic [31:0]       mem_wdata;
   logic              mem_we;
   logic              access_err;

   assign req_ready_o = (state_q == S_IDLE) && !rst_i;
   assign busy_o      = (state_q != S_IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

   assign idx     = addr_q[IDX_W+1:2];
   assign rd_word = mem_q[idx];

   // Range check uses the full word index so out-of-range words never alias onto the store.
   assign access_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W) ||
                       (wr_q && (be_q == 4'b0000));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_we      = 1'b0;
      mem_wdata   = rd_word;
      for (int n = 0; n < 4; n++) begin
         if (be_q[n]) begin
            mem_wdata[8*n +: 8] = wdata_q[8*n +: 8];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (req_valid_i && req_ready_o) begin
               wr_d    = req_write_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               be_d    = req_be_i;
               cnt_d   = LAT_C;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = access_err;
               rsp_rdata_d = (access_err || wr_q) ? 32'h0 : rd_word;
               mem_we      = wr_q && !access_err;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state and the store; reset wins over a pending write so an aborted store never lands.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'h0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         if (mem_we) begin
            mem_q[idx] <= mem_wdata;
         end
      end
   end

   // Request holding registers; only meaningful while busy, so left out of reset.
   always_ff @(posedge clk_i) begin
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 instance for functional scenarios,
// LATENCY=0 instance for the back-to-back streaming scenario; queue-based scoreboards.
module tb_data_mem_responder;

   localparam int LAT = 2;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err, busy;
   logic [31:0] rsp_rdata;

   logic        req_valid0, req_ready0, req_write0;
   logic [31:0] req_addr0, req_wdata0;
   logic [3:0]  req_be0;
   logic        rsp_valid0, rsp_ready0, rsp_err0, busy0;
   logic [31:0] rsp_rdata0;

   logic [31:0] mdl  [0:127];
   logic [31:0] mdl0 [0:127];
   exp_t        q_exp[$];
   exp_t        q_exp0[$];

   int n_cmp = 0;
   int n_bad = 0;

   data_mem_responder #(.DEPTH(128), .LATENCY(LAT), .CNT_W(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .busy_o(busy)
   );

   data_mem_responder #(.DEPTH(128), .LATENCY(0), .CNT_W(4)) dut0 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_write_i(req_write0),
      .req_addr_i(req_addr0), .req_wdata_i(req_wdata0), .req_be_i(req_be0),
      .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_rdata_o(rsp_rdata0),
      .rsp_err_o(rsp_err0), .busy_o(busy0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   // Reference model: applies the access to the chosen model and queues the expected response.
   task automatic push_exp(input bit sel, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
      exp_t        e;
      logic        bad;
      logic [31:0] word;
      bad     = (a[1:0] != 2'b00) || (a[31:2] >= 30'd128) || (w && be == 4'd0);
      e.err   = bad;
      e.rdata = 32'h0;
      if (!bad) begin
         word = sel ? mdl0[a[8:2]] : mdl[a[8:2]];
         if (w) begin
            for (int n = 0; n < 4; n++) begin
               if (be[n]) word[8*n +: 8] = wd[8*n +: 8];
            end
            if (sel) mdl0[a[8:2]] = word;
            else     mdl[a[8:2]]  = word;
         end else begin
            e.rdata = word;
         end
      end
      if (sel) q_exp0.push_back(e);
      else     q_exp.push_back(e);
   endtask

   task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be);
      bit acc;
      acc = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk); #1;
         if (acc) break;
      end
      // Scramble inputs after acceptance: the captured copy must be what gets used.
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      n_cmp++;
      if (!acc) begin
         n_bad++;
         $display("FAIL accept addr=%08h: accepted=%0b required=1", a, acc);
      end
   endtask

   // Called just after the acceptance edge; checks latency, payload, handshake and return to idle.
   task automatic collect_rsp(input string name);
      exp_t e;
      int   lat;
      bit   seen;
      lat  = 0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!seen || lat != LAT + 2) begin
         n_bad++;
         $display("FAIL %s latency: got %0d cycles (seen=%0b) required %0d", name, lat, seen, LAT + 2);
      end
      if (q_exp.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s scoreboard: queue empty, required one entry", name);
      end else begin
         e = q_exp.pop_front();
         n_cmp++;
         if (rsp_rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL %s rdata: got %08h required %08h", name, rsp_rdata, e.rdata);
         end
         n_cmp++;
         if (rsp_err !== e.err) begin
            n_bad++;
            $display("FAIL %s err: got %0b required %0b", name, rsp_err, e.err);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, busy, req_ready, rsp_err, rsp_rdata} !== {3'b001, 1'b0, 32'h0}) begin
         n_bad++;
         $display("FAIL %s post-handshake {valid,busy,ready,err,rdata}: got %b_%b_%b_%b_%08h required 0_0_1_0_00000000",
                  name, rsp_valid, busy, req_ready, rsp_err, rsp_rdata);
      end
   endtask

   task automatic xact(input string name, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
      push_exp(1'b0, w, a, wd, be);
      drive_req(w, a, wd, be);
      collect_rsp(name);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ready_in_reset: got %0b required 0", req_ready);
      end
      rst = 1'b0;
      for (int i = 0; i < 128; i++) begin
         mdl[i]  = 32'h0;
         mdl0[i] = 32'h0;
      end
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_err, busy, req_ready, rsp_rdata} !== {4'b0001, 32'h0}) begin
         n_bad++;
         $display("FAIL reset_state {valid,err,busy,ready,rdata}: got %b_%b_%b_%b_%08h required 0_0_0_1_00000000",
                  rsp_valid, rsp_err, busy, req_ready, rsp_rdata);
      end
      xact("reset_mem_clear", 1'b0, 32'h0000_0080, 32'h0, 4'h0);
   endtask

   task automatic test_basic();
      xact("store_10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
      xact("load_10",  1'b0, 32'h0000_0010, 32'h0, 4'b0000);
   endtask

   task automatic test_merge();
      xact("merge_store_full", 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b1111);
      xact("merge_store_part", 1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0101);
      xact("merge_load",       1'b0, 32'h0000_0020, 32'h0, 4'b0000);
      n_cmp++;
      if (mdl[8] !== 32'hAA22_CC44) begin
         n_bad++;
         $display("FAIL merge_model: got %08h required aa22cc44", mdl[8]);
      end
   endtask

   task automatic test_errors();
      xact("err_misaligned_load", 1'b0, 32'h0000_0013, 32'h0, 4'b0000);
      xact("err_range_store",     1'b1, 32'h0000_0200, 32'h1234_5678, 4'b1111);
      xact("word0_unchanged",     1'b0, 32'h0000_0000, 32'h0, 4'b0000);
      xact("err_be_zero_store",   1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000);
      xact("be_zero_no_effect",   1'b0, 32'h0000_0020, 32'h0, 4'b0000);
      xact("err_high_addr_load",  1'b0, 32'h8000_0010, 32'h0, 4'b0000);
   endtask

   task automatic test_backpressure();
      exp_t        e;
      logic [31:0] held_rdata;
      logic        held_err;
      int          lat;
      bit          seen;
      push_exp(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'b0000);
      drive_req(1'b0, 32'h0000_0010, 32'h0, 4'b0000);
      lat  = 0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!seen || lat != LAT + 2) begin
         n_bad++;
         $display("FAIL bp latency: got %0d cycles (seen=%0b) required %0d", lat, seen, LAT + 2);
      end
      e = q_exp.pop_front();
      held_rdata = rsp_rdata;
      held_err   = rsp_err;
      n_cmp++;
      if ({held_err, held_rdata} !== {e.err, e.rdata}) begin
         n_bad++;
         $display("FAIL bp data: got err=%0b rdata=%08h required err=%0b rdata=%08h",
                  held_err, held_rdata, e.err, e.rdata);
      end
      // Offer the next request while the response is stalled.
      push_exp(1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'b0000);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0020; req_wdata = 32'h0; req_be = 4'h0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({rsp_valid, rsp_err, rsp_rdata, req_ready, busy} !== {1'b1, held_err, held_rdata, 2'b01}) begin
            n_bad++;
            $display("FAIL bp_hold cycle %0d {valid,err,rdata,ready,busy}: got %b_%b_%08h_%b_%b required 1_%b_%08h_0_1",
                     c, rsp_valid, rsp_err, rsp_rdata, req_ready, busy, held_err, held_rdata);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, busy, req_ready} !== 3'b001) begin
         n_bad++;
         $display("FAIL bp_release {valid,busy,ready}: got %b_%b_%b required 0_0_1", rsp_valid, busy, req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      collect_rsp("bp_second");
   endtask

   task automatic test_reset_mid();
      drive_req(1'b1, 32'h0000_0040, 32'h5555_5555, 4'b1111);
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_ready_in_reset: got %0b required 0", req_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({req_ready, busy} !== 2'b10) begin
         n_bad++;
         $display("FAIL midreset_after {ready,busy}: got %b_%b required 1_0", req_ready, busy);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_cmp++;
         if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_no_rsp cycle %0d: got %0b required 0", c, rsp_valid);
         end
      end
      for (int i = 0; i < 128; i++) mdl[i] = 32'h0;
      xact("midreset_load_40", 1'b0, 32'h0000_0040, 32'h0, 4'b0000);
      xact("midreset_load_10", 1'b0, 32'h0000_0010, 32'h0, 4'b0000);
   endtask

   task automatic test_back_to_back_lat0();
      localparam int N = 12;
      logic        w_t  [N];
      logic [31:0] a_t  [N];
      logic [31:0] wd_t [N];
      logic [3:0]  be_t [N];
      exp_t        e;
      int          idx, cyc, last_acc, rsp_cnt;
      bit          acc;
      for (int i = 0; i < N; i++) begin
         w_t[i]  = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
         a_t[i]  = 32'($urandom_range(0, 3)) << 2;
         wd_t[i] = $urandom;
         be_t[i] = 4'($urandom_range(1, 15));
      end
      a_t[N-2] = 32'h0000_0006;
      idx = 0; cyc = 0; last_acc = -100; rsp_cnt = 0;
      rsp_ready0 = 1'b1;
      @(posedge clk); #1;
      req_valid0 = 1'b1; req_write0 = w_t[0]; req_addr0 = a_t[0]; req_wdata0 = wd_t[0]; req_be0 = be_t[0];
      for (int c = 0; c < 200 && rsp_cnt < N; c++) begin
         @(negedge clk);
         if (rsp_valid0) begin
            rsp_cnt++;
            n_cmp++;
            if (cyc != last_acc + 1) begin
               n_bad++;
               $display("FAIL lat0_latency rsp %0d: edge %0d required %0d", rsp_cnt, cyc, last_acc + 1);
            end
            if (q_exp0.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL lat0_scoreboard: unexpected response %0d, queue empty", rsp_cnt);
            end else begin
               e = q_exp0.pop_front();
               n_cmp++;
               if ({rsp_err0, rsp_rdata0} !== {e.err, e.rdata}) begin
                  n_bad++;
                  $display("FAIL lat0_data rsp %0d: got err=%0b rdata=%08h required err=%0b rdata=%08h",
                           rsp_cnt, rsp_err0, rsp_rdata0, e.err, e.rdata);
               end
            end
         end
         acc = req_ready0 && req_valid0;
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            if (idx > 0) begin
               n_cmp++;
               if (cyc - last_acc != 3) begin
                  n_bad++;
                  $display("FAIL lat0_throughput req %0d: spacing %0d required 3", idx, cyc - last_acc);
               end
            end
            last_acc = cyc;
            push_exp(1'b1, w_t[idx], a_t[idx], wd_t[idx], be_t[idx]);
            idx++;
            if (idx < N) begin
               req_write0 = w_t[idx]; req_addr0 = a_t[idx]; req_wdata0 = wd_t[idx]; req_be0 = be_t[idx];
            end else begin
               req_valid0 = 1'b0;
            end
         end
      end
      req_valid0 = 1'b0;
      rsp_ready0 = 1'b0;
      n_cmp++;
      if (rsp_cnt != N) begin
         n_bad++;
         $display("FAIL lat0_count: got %0d responses required %0d", rsp_cnt, N);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
      rsp_ready = 1'b0;
      req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0; req_be0 = 4'h0;
      rsp_ready0 = 1'b0;
      test_reset();
      test_basic();
      test_merge();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_back_to_back_lat0();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Multi-cycle data-memory responder: the target end of the CPU's load/store data path.
Accepts one request at a time over a valid/ready request channel and holds a word-organised store with byte enables.
Returns read data or write acknowledgement over a valid/ready response channel after a programmable number of wait states.
Used in place of the zero-wait data memory when a CPU front end with load/store stall handshakes is connected.

Parameters:
DEPTH, 128, number of 32-bit words in the store; word index = req_addr_i[31:2]
LATENCY, 2, wait-state cycles between request acceptance and the access; legal range 0..15
CNT_W, 4, width of the wait-state counter; must satisfy 2^CNT_W > LATENCY

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous active-high reset
req_valid_i  input  1  request present
req_ready_o  output  1  responder can accept a request this cycle
req_write_i  input  1  1 = store, 0 = load
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data, lane n = bits [8n+7:8n]
req_be_i  input  4  byte enables for stores; ignored for loads
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  requester accepts the response
rsp_rdata_o  output  32  load data; 0 for stores and errored requests
rsp_err_o  output  1  request was rejected, with no memory effect
busy_o  output  1  a request is in flight (WAIT or RESP)

Behaviour:
- Reset (rst_i high at an edge):
  - state to IDLE; counter to 0.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, busy_o=0.
  - all DEPTH words cleared to 0.
  - req_ready_o is 0 while rst_i is high.
- Reset mid-operation: aborts any in-flight request; a pending store is never written; the response is dropped.
- States: IDLE, WAIT, RESP. req_ready_o = (state==IDLE) && !rst_i; busy_o = (state!=IDLE). Strictly one outstanding request; no overlap of response and the next acceptance.
- IDLE: acceptance is req_valid_i && req_ready_o at an edge.
  - Captures write, addr, wdata and be into holding registers.
  - Loads counter with LATENCY and goes to WAIT.
  - Request inputs are don't-care after the acceptance edge.
- WAIT: when counter != 0, decrement it and stay in WAIT.
- WAIT, counter == 0: perform the access at this edge and go to RESP:
  - Error check: err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH) || (write && be==0).
  - Error: no memory change; rsp_rdata_o=0; rsp_err_o=1.
  - Load: rsp_rdata_o = full word mem[addr[31:2]]; rsp_err_o=0.
  - Store: write only the enabled byte lanes; other lanes keep their value; rsp_rdata_o=0; rsp_err_o=0.
  - rsp_valid_o goes to 1 at this edge.
- Latency: accepted at edge k, rsp_valid_o is high in the cycle after edge k+1+LATENCY. With LATENCY=0 the response is visible one cycle after acceptance.
- RESP:
  - rsp_valid_o, rsp_rdata_o and rsp_err_o are held stable until rsp_valid_o && rsp_ready_i at an edge.
  - On that edge: rsp_valid_o=0, rsp_rdata_o and rsp_err_o cleared to 0, go to IDLE.
  - A new request may be accepted at the edge after that.
  - rsp_ready_i is ignored outside RESP; the response is never dropped without a handshake.
- Store-then-load to the same word returns the merged post-store value.
- Out-of-range words are never aliased or wrapped.
- Throughput with rsp_ready_i held high: one request per LATENCY+3 cycles.

Test Plan:
- Reset, then LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be 1111 accepted at edge 0 -> rsp_valid_o high after edge 3, rsp_err_o=0, rsp_rdata_o=0. Load 0x10 -> rsp_rdata_o=0xDEADBEEF.
- Byte-lane merge: store 0xAABBCCDD be 1111 to 0x20, then store 0x11223344 be 0101 to 0x20 -> load 0x20 returns 0xAA22CC44.
- Errors:
  - load 0x13 -> rsp_err_o=1, rdata 0.
  - store to word index 128 (addr 0x200) -> rsp_err_o=1, and word 0 is still unchanged.
  - store be 0000 -> rsp_err_o=1.
- Response backpressure: rsp_ready_i low for 5 cycles after rsp_valid_o rises -> outputs stable, req_ready_o=0, busy_o=1 throughout. A req_valid_i offered meanwhile is accepted only the cycle after the response handshake.
- Reset mid-operation: store 0x55555555 to 0x40 accepted, then rst_i pulsed during WAIT -> no response is issued, req_ready_o=1 after reset, load 0x40 returns 0.
- LATENCY=0 build: back-to-back load/store stream with rsp_ready_i=1 -> rsp_valid_o one cycle after each acceptance, one request every 3 cycles, data matches a reference model.
